// File: rtl/h14tx_pkg.sv
// Shared HDMI 1.4 TX types: TMDS period codes and data-island length constants.
package h14tx_pkg;

    // Period select driven to the TMDS channel encoders.
    typedef enum logic [2:0] {
        Control       = 3'd0,
        VideoActive   = 3'd1,
        VideoPreamble = 3'd2,
        VideoGuard    = 3'd3,
        DataPreamble  = 3'd4,
        DataGuard     = 3'd5,
        DataActive    = 3'd6
    } period_t;

    localparam int unsigned IslandPreambleLen = 8;
    localparam int unsigned IslandGuardLen    = 2;
    localparam int unsigned PacketLen         = 32;

    // Position counter within a scheduler state; sized for the longest state.
    localparam int unsigned CycleCntWidth     = 5;

endpackage

// File: rtl/h14tx_rr_arbiter.sv
// Round-robin arbiter for island packet slots.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-source request vector
//   adv      : strobe; commits the current grant and moves the pointer
//   gnt_c    : combinational one-hot grant (zero when nothing requests)
//   idx_c    : combinational index of the granted source
module h14tx_rr_arbiter #(
    parameter  int unsigned NumSources = 2,
    localparam int unsigned IdxWidth   = (NumSources > 1) ? $clog2(NumSources) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NumSources-1:0] req,
    input  logic                  adv,
    output logic [NumSources-1:0] gnt_c,
    output logic [IdxWidth-1:0]   idx_c
);

    // Index where the next search starts (one past the last granted source).
    logic [IdxWidth-1:0] ptr;
    logic [IdxWidth-1:0] cand_c;
    logic                found_c;

    // First requesting source at or after ptr, wrapping.
    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        cand_c  = '0;
        found_c = 1'b0;
        for (int unsigned i = 0; i < NumSources; i++) begin
            cand_c = IdxWidth'((32'(ptr) + i) % NumSources);
            if (!found_c && req[cand_c]) begin
                found_c        = 1'b1;
                idx_c          = cand_c;
                gnt_c[cand_c]  = 1'b1;
            end
        end
    end

    // Pointer moves only when a grant is actually issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv && found_c) begin
            ptr <= IdxWidth'((32'(idx_c) + 32'd1) % NumSources);
        end
    end

endmodule

// File: rtl/h14tx_island_scheduler.sv
// Inserts one data island per line into horizontal blanking and shares its
// packet slots among NumSources requesters in round-robin order.
//   clk, rst      : pixel clock, synchronous active-high reset
//   x, y          : raster position (y is informational only)
//   video_timings : video period for the same x/y
//   req           : level-held per-source packet requests
//   timings       : registered merged period
//   gnt           : one-hot pulse on the first cycle of a granted packet
//   slot_src      : source owning the current packet slot
//   slot_index    : character index within the current packet, 0 elsewhere
module h14tx_island_scheduler
    import h14tx_pkg::*;
#(
    parameter  int unsigned BitWidth    = 11,
    parameter  int unsigned BitHeight   = 10,
    parameter  int unsigned FrameWidth  = 1650,
    parameter  int unsigned ActiveWidth = 1280,
    parameter  int unsigned NumSources  = 2,
    parameter  int unsigned ControlMin  = 12,
    parameter  int unsigned MaxPackets  = 18,
    localparam int unsigned SrcWidth    = (NumSources > 1) ? $clog2(NumSources) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BitWidth-1:0]   x,
    input  logic [BitHeight-1:0]  y,
    input  period_t               video_timings,
    input  logic [NumSources-1:0] req,
    output period_t               timings,
    output logic [NumSources-1:0] gnt,
    output logic [SrcWidth-1:0]   slot_src,
    output logic [4:0]            slot_index
);

    localparam int VideoPreambleStart = int'(FrameWidth) - 10;
    localparam int IslandStart        = int'(ActiveWidth) + int'(ControlMin);
    localparam int FitRaw             = (VideoPreambleStart - int'(ControlMin) - IslandStart - 12) / 32;
    localparam int FitPackets         = (FitRaw < int'(MaxPackets)) ? FitRaw : int'(MaxPackets);
    localparam int unsigned PktCntWidth = $clog2(MaxPackets + 1);

    localparam logic [CycleCntWidth-1:0] LastPreamble = CycleCntWidth'(IslandPreambleLen - 1);
    localparam logic [CycleCntWidth-1:0] LastGuard    = CycleCntWidth'(IslandGuardLen - 1);
    localparam logic [CycleCntWidth-1:0] LastPacket   = CycleCntWidth'(PacketLen - 1);

    // An island that cannot hold a single packet is a configuration error.
    if (FitPackets < 1) begin : g_fit_check
        $error("h14tx_island_scheduler: blanking too short for one packet");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_LEAD_GUARD,
        S_PACKET,
        S_TRAIL_GUARD
    } state_t;

    state_t                   state, state_d;
    logic [CycleCntWidth-1:0] cnt, cnt_d;
    logic [PktCntWidth-1:0]   pkt_cnt, pkt_cnt_d;
    logic                     pkt_start_c;
    logic [NumSources-1:0]    arb_gnt_c;
    logic [SrcWidth-1:0]      arb_idx_c;
    period_t                  timings_d;
    logic [NumSources-1:0]    gnt_d;
    logic [SrcWidth-1:0]      slot_src_d;
    logic [4:0]               slot_index_d;

    logic unused_y;
    assign unused_y = ^y;

    h14tx_rr_arbiter #(
        .NumSources (NumSources)
    ) u_arbiter (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .adv   (pkt_start_c),
        .gnt_c (arb_gnt_c),
        .idx_c (arb_idx_c)
    );

    // State register; the registered outputs describe the state just entered,
    // which gives the one-cycle latency from x to timings.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pkt_cnt    <= '0;
            timings    <= Control;
            gnt        <= '0;
            slot_src   <= '0;
            slot_index <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            pkt_cnt    <= pkt_cnt_d;
            timings    <= timings_d;
            gnt        <= gnt_d;
            slot_src   <= slot_src_d;
            slot_index <= slot_index_d;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        pkt_cnt_d    = pkt_cnt;
        pkt_start_c  = 1'b0;
        timings_d    = video_timings;
        gnt_d        = '0;
        slot_src_d   = slot_src;
        slot_index_d = '0;

        unique case (state)
            S_IDLE: begin
                if (x == BitWidth'(IslandStart) && |req) begin
                    state_d   = S_PREAMBLE;
                    cnt_d     = '0;
                    pkt_cnt_d = '0;
                end
            end
            S_PREAMBLE: begin
                if (cnt == LastPreamble) begin
                    state_d = S_LEAD_GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CycleCntWidth'(1);
                end
            end
            S_LEAD_GUARD: begin
                if (cnt == LastGuard) begin
                    state_d     = S_PACKET;
                    cnt_d       = '0;
                    pkt_start_c = 1'b1;
                    pkt_cnt_d   = pkt_cnt + PktCntWidth'(1);
                end else begin
                    cnt_d = cnt + CycleCntWidth'(1);
                end
            end
            S_PACKET: begin
                if (cnt == LastPacket) begin
                    cnt_d = '0;
                    // Back-to-back packet only while someone still asks and room remains.
                    if (|req && pkt_cnt < PktCntWidth'(FitPackets)) begin
                        pkt_start_c = 1'b1;
                        pkt_cnt_d   = pkt_cnt + PktCntWidth'(1);
                    end else begin
                        state_d = S_TRAIL_GUARD;
                    end
                end else begin
                    cnt_d = cnt + CycleCntWidth'(1);
                end
            end
            S_TRAIL_GUARD: begin
                if (cnt == LastGuard) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CycleCntWidth'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        unique case (state_d)
            S_PREAMBLE:                  timings_d = DataPreamble;
            S_LEAD_GUARD, S_TRAIL_GUARD: timings_d = DataGuard;
            S_PACKET: begin
                timings_d    = DataActive;
                slot_index_d = cnt_d;
            end
            default:                     timings_d = video_timings;
        endcase

        if (pkt_start_c) begin
            gnt_d      = arb_gnt_c;
            slot_src_d = arb_idx_c;
        end
    end

endmodule

// File: tb/tb_h14tx_island_scheduler.sv
// Directed bench for h14tx_island_scheduler at 720p defaults.
module tb_h14tx_island_scheduler;
    import h14tx_pkg::*;

    localparam int IS = 1292;   // island start x
    localparam int P0 = 1302;   // first packet x

    logic        clk;
    logic        rst;
    logic [10:0] x;
    logic [9:0]  y;
    period_t     video_timings;
    logic [1:0]  req;
    period_t     timings;
    logic [1:0]  gnt;
    logic [0:0]  slot_src;
    logic [4:0]  slot_index;

    int n_checks = 0;
    int n_fail   = 0;
    int line     = 0;

    h14tx_island_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .x             (x),
        .y             (y),
        .video_timings (video_timings),
        .req           (req),
        .timings       (timings),
        .gnt           (gnt),
        .slot_src      (slot_src),
        .slot_index    (slot_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference video timing for one 720p line.
    function automatic period_t vt(input int xv);
        if (xv < 1280)      return VideoActive;
        else if (xv >= 1648) return VideoGuard;
        else if (xv >= 1640) return VideoPreamble;
        else                 return Control;
    endfunction

    // Expected merged period for a line carrying npk packets (0 = no island).
    function automatic period_t exp_t(input int xv, input int npk);
        int pend;
        pend = P0 + 32 * npk;
        if (npk > 0) begin
            if (xv >= IS && xv < IS + 8)         return DataPreamble;
            if (xv >= IS + 8 && xv < P0)         return DataGuard;
            if (xv >= P0 && xv < pend)           return DataActive;
            if (xv >= pend && xv < pend + 2)     return DataGuard;
        end
        return vt(xv);
    endfunction

    function automatic logic [4:0] exp_idx(input int xv, input int npk);
        if (npk > 0 && xv >= P0 && xv < P0 + 32 * npk) return 5'((xv - P0) % 32);
        return 5'd0;
    endfunction

    // Present one x value; outputs for it are visible on return.
    task automatic present(input int xv);
        if (xv == 0) line = line + 1;
        x             = 11'(xv);
        y             = 10'(line % 750);
        video_timings = vt(xv);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        present(0);
        present(1);
        n_checks++; if (timings !== Control) begin n_fail++; $display("FAIL reset_timings got=%0d exp=%0d", timings, Control); end
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        n_checks++; if (slot_src !== 1'b0) begin n_fail++; $display("FAIL reset_slot_src got=%b exp=0", slot_src); end
        n_checks++; if (slot_index !== 5'd0) begin n_fail++; $display("FAIL reset_slot_index got=%0d exp=0", slot_index); end
        rst = 1'b0;
    endtask

    task automatic test_single_island;
        logic [1:0] eg;
        req = 2'b01;
        for (int xv = 1280; xv < 1650; xv++) begin
            present(xv);
            eg = (xv == P0) ? 2'b01 : 2'b00;
            n_checks++; if (timings !== exp_t(xv, 1)) begin n_fail++; $display("FAIL single_timings x=%0d got=%0d exp=%0d", xv, timings, exp_t(xv, 1)); end
            n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL single_gnt x=%0d got=%b exp=%b", xv, gnt, eg); end
            n_checks++; if (slot_index !== exp_idx(xv, 1)) begin n_fail++; $display("FAIL single_slot_index x=%0d got=%0d exp=%0d", xv, slot_index, exp_idx(xv, 1)); end
            if (xv >= P0 && xv < P0 + 32) begin
                n_checks++; if (slot_src !== 1'b0) begin n_fail++; $display("FAIL single_slot_src x=%0d got=%b exp=0", xv, slot_src); end
            end
            if (gnt != 2'b00) req = 2'b00;
        end
        req = 2'b00;
    endtask

    task automatic test_both_sources;
        logic [1:0] eg;
        logic       es;
        int         k;
        rst = 1'b1;
        present(0);
        rst = 1'b0;
        req = 2'b11;
        for (int xv = 1280; xv < 1650; xv++) begin
            present(xv);
            k  = (xv - P0) / 32;
            eg = 2'b00;
            if (xv >= P0 && xv < P0 + 320 && (xv - P0) % 32 == 0) eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            es = 1'(k % 2);
            n_checks++; if (timings !== exp_t(xv, 10)) begin n_fail++; $display("FAIL both_timings x=%0d got=%0d exp=%0d", xv, timings, exp_t(xv, 10)); end
            n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL both_gnt x=%0d got=%b exp=%b", xv, gnt, eg); end
            n_checks++; if (slot_index !== exp_idx(xv, 10)) begin n_fail++; $display("FAIL both_slot_index x=%0d got=%0d exp=%0d", xv, slot_index, exp_idx(xv, 10)); end
            if (xv >= P0 && xv < P0 + 320) begin
                n_checks++; if (slot_src !== es) begin n_fail++; $display("FAIL both_slot_src x=%0d got=%b exp=%b", xv, slot_src, es); end
            end
        end
        req = 2'b00;
    endtask

    task automatic test_empty_req;
        req = 2'b00;
        for (int l = 0; l < 2; l++) begin
            for (int xv = 0; xv < 1650; xv++) begin
                present(xv);
                n_checks++; if (timings !== vt(xv)) begin n_fail++; $display("FAIL empty_timings x=%0d got=%0d exp=%0d", xv, timings, vt(xv)); end
                n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL empty_gnt x=%0d got=%b exp=00", xv, gnt); end
                n_checks++; if (slot_index !== 5'd0) begin n_fail++; $display("FAIL empty_slot_index x=%0d got=%0d exp=0", xv, slot_index); end
            end
        end
    endtask

    task automatic test_late_req;
        logic [1:0] eg;
        req = 2'b00;
        for (int xv = 1280; xv < 1650; xv++) begin
            if (xv == IS + 1) req = 2'b01;
            present(xv);
            n_checks++; if (timings !== vt(xv)) begin n_fail++; $display("FAIL late_timings x=%0d got=%0d exp=%0d", xv, timings, vt(xv)); end
            n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL late_gnt x=%0d got=%b exp=00", xv, gnt); end
        end
        for (int xv = 0; xv < 1650; xv++) begin
            present(xv);
            eg = (xv == P0) ? 2'b01 : 2'b00;
            n_checks++; if (timings !== exp_t(xv, 1)) begin n_fail++; $display("FAIL late_next_timings x=%0d got=%0d exp=%0d", xv, timings, exp_t(xv, 1)); end
            n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL late_next_gnt x=%0d got=%b exp=%b", xv, gnt, eg); end
            if (gnt != 2'b00) req = 2'b00;
        end
        req = 2'b00;
    endtask

    task automatic test_reset_mid_packet;
        logic [1:0] eg;
        req = 2'b01;
        for (int xv = 1280; xv < 1310; xv++) begin
            present(xv);
            if (xv == P0) begin
                n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL midrst_first_gnt got=%b exp=01", gnt); end
            end
            if (gnt != 2'b00) req = 2'b00;
        end
        rst = 1'b1;
        present(1310);
        rst = 1'b0;
        n_checks++; if (timings !== Control) begin n_fail++; $display("FAIL midrst_timings got=%0d exp=%0d", timings, Control); end
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL midrst_gnt got=%b exp=00", gnt); end
        n_checks++; if (slot_index !== 5'd0) begin n_fail++; $display("FAIL midrst_slot_index got=%0d exp=0", slot_index); end
        for (int xv = 1311; xv < 1650; xv++) begin
            present(xv);
            n_checks++; if (timings !== vt(xv)) begin n_fail++; $display("FAIL midrst_after_timings x=%0d got=%0d exp=%0d", xv, timings, vt(xv)); end
        end
        req = 2'b11;
        for (int xv = 0; xv < 1650; xv++) begin
            present(xv);
            eg = (xv == P0) ? 2'b01 : 2'b00;
            n_checks++; if (timings !== exp_t(xv, 1)) begin n_fail++; $display("FAIL midrst_next_timings x=%0d got=%0d exp=%0d", xv, timings, exp_t(xv, 1)); end
            n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL midrst_ptr_gnt x=%0d got=%b exp=%b", xv, gnt, eg); end
            if (gnt != 2'b00) req = 2'b00;
        end
        req = 2'b00;
    endtask

    task automatic test_round_robin;
        logic [1:0] eg;
        logic       es;
        req = 2'b10;
        for (int xv = 1280; xv < 1650; xv++) begin
            present(xv);
            eg = (xv == P0) ? 2'b10 : 2'b00;
            n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL rr_src1_gnt x=%0d got=%b exp=%b", xv, gnt, eg); end
            if (xv >= P0 && xv < P0 + 32) begin
                n_checks++; if (slot_src !== 1'b1) begin n_fail++; $display("FAIL rr_src1_slot_src x=%0d got=%b exp=1", xv, slot_src); end
            end
            if (gnt != 2'b00) req = 2'b00;
        end
        req = 2'b11;
        for (int xv = 0; xv < 1650; xv++) begin
            present(xv);
            eg = 2'b00;
            if (xv == P0)      eg = 2'b01;
            if (xv == P0 + 32) eg = 2'b10;
            es = (xv >= P0 + 32) ? 1'b1 : 1'b0;
            n_checks++; if (timings !== exp_t(xv, 2)) begin n_fail++; $display("FAIL rr_timings x=%0d got=%0d exp=%0d", xv, timings, exp_t(xv, 2)); end
            n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt x=%0d got=%b exp=%b", xv, gnt, eg); end
            if (xv >= P0 && xv < P0 + 64) begin
                n_checks++; if (slot_src !== es) begin n_fail++; $display("FAIL rr_slot_src x=%0d got=%b exp=%b", xv, slot_src, es); end
            end
            if (gnt == 2'b10) req = 2'b00;
        end
        req = 2'b00;
    endtask

    initial begin
        rst           = 1'b1;
        x             = '0;
        y             = '0;
        video_timings = Control;
        req           = 2'b00;
        test_reset();
        test_single_island();
        test_both_sources();
        test_empty_req();
        test_late_req();
        test_reset_mid_packet();
        test_round_robin();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
